// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: memory-wait FSM
// encoding, default sizes and the freeze/flush control bundle with its decoder.
package pipe_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Field order is fixed: freezes from the front of the pipe backwards, then flushes, then PC select.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if;
    logic freeze_id;
    logic freeze_mem;
    logic flush_if;
    logic flush_id;
    logic pc_sel;
  } ctrl_t;

  // A memory stall outranks a taken branch, which outranks a load-use bubble.
  function automatic ctrl_t decode_ctrl(input logic mem_stall, input logic b_exe,
                                        input logic hazard);
    ctrl_t c;
    c = '0;
    if (mem_stall) begin
      c.freeze_pc  = 1'b1;
      c.freeze_if  = 1'b1;
      c.freeze_id  = 1'b1;
      c.freeze_mem = 1'b1;
    end else if (b_exe) begin
      c.flush_if = 1'b1;
      c.flush_id = 1'b1;
      c.pc_sel   = 1'b1;
    end else if (hazard) begin
      c.freeze_pc = 1'b1;
      c.freeze_if = 1'b1;
      c.flush_id  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with the SRAM memory-wait FSM.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             B_EXE,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_go,
  output logic             freeze_pc,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_mem,
  output logic             flush_if,
  output logic             flush_id,
  output logic             pc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  ctrl_t             ctrl;

  // The request is honoured in the same cycle it appears, so IDLE already stalls.
  assign mem_stall = (state == WAIT) || ((state == IDLE) && mem_req);
  assign mem_go    = mem_stall;
  assign ctrl      = decode_ctrl(mem_stall, B_EXE, hazard);

  assign freeze_pc  = ctrl.freeze_pc;
  assign freeze_if  = ctrl.freeze_if;
  assign freeze_id  = ctrl.freeze_id;
  assign freeze_mem = ctrl.freeze_mem;
  assign flush_if   = ctrl.flush_if;
  assign flush_id   = ctrl.flush_id;
  assign pc_sel     = ctrl.pc_sel;

  // DONE is a forced one-cycle release so a back-to-back access is seen fresh in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_err <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic any_freeze;
  assign any_freeze = ctrl.freeze_pc | ctrl.freeze_if | ctrl.freeze_id | ctrl.freeze_mem;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_freeze),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.pc_sel),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
